pipe_stall_ctrl: RTL

Pipeline sequencing controller for the five-stage MIPS core. It drives the write enables and bubble inserts for the F/D/E pipeline registers and owns the multi-cycle multiply/divide busy counter. It applies exception-request priority over all stalls and keeps two free-running performance counters. It sits between the hazard unit, CP0 and the D/E pipeline registers.

---
 rtl/pipe_stall_ctrl_if.sv | 35 +++
 rtl/pipe_stall_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Hazard/CP0 inputs and pipeline-control outputs of the
//                pipeline sequencing controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_stall_ctrl_if;
  logic        stall_data;
  logic        md_use_D;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        req;
  logic        pc_we;
  logic        d_we;
  logic        e_clr;
  logic        md_go;
  logic        busy;
  logic        stall;
  logic [31:0] stall_cycles;
  logic [31:0] req_count;

  modport master (
    output stall_data, md_use_D, md_start_E, md_is_div_E, req,
    input  pc_we, d_we, e_clr, md_go, busy, stall, stall_cycles, req_count
  );

  modport slave (
    input  stall_data, md_use_D, md_start_E, md_is_div_E, req,
    output pc_we, d_we, e_clr, md_go, busy, stall, stall_cycles, req_count
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : F/D/E stall and bubble control, mult/div busy counter,
//                exception-request priority and stall/request counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic      clk,
  input  wire logic      reset,
  pipe_stall_ctrl_if.slave ctl
);

  localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  r_cnt;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_req_count;

  logic w_busy;
  logic w_md_go;
  logic w_md_stall;
  logic w_stall;

  // A pending request flushes the younger E instruction, so it never starts
  // the MD unit, and the handler PC must load regardless of any hazard.
  assign w_busy     = (r_cnt != 4'd0);
  assign w_md_go    = ctl.md_start_E & ~w_busy & ~ctl.req;
  assign w_md_stall = ctl.md_use_D & (w_busy | ctl.md_start_E);
  assign w_stall    = ~ctl.req & (ctl.stall_data | w_md_stall);

  assign ctl.busy         = w_busy;
  assign ctl.md_go        = w_md_go;
  assign ctl.stall        = w_stall;
  assign ctl.pc_we        = ~w_stall;
  assign ctl.d_we         = ~w_stall;
  assign ctl.e_clr        = w_stall;
  assign ctl.stall_cycles = r_stall_cycles;
  assign ctl.req_count    = r_req_count;

  // An in-flight operation belongs to an older instruction and keeps
  // counting through a request; a start while busy is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= 4'd0;
      r_stall_cycles <= 32'd0;
      r_req_count    <= 32'd0;
    end else begin
      if (w_md_go) begin
        r_cnt <= ctl.md_is_div_E ? c_DIV_LOAD : c_MULT_LOAD;
      end else if (w_busy) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (ctl.req) begin
        r_req_count <= r_req_count + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire
